ls_mem_ctrl: RTL and testbench

Memory-stage load/store controller. It sits directly downstream of the load/store functional unit and consumes that unit's effective address, store data, access size, misalign flag and zero-extend flag. It drives a single-outstanding request/acknowledge data-memory port and returns aligned, extended load data or a RISC-V exception code to the writeback path. It stalls the pipeline via a ready/valid handshake.

---
 rtl/ls_mem_ctrl_pkg.sv | 11 +
 rtl/ls_mem_ctrl_align.sv | 22 ++
 rtl/ls_mem_ctrl.sv | 114 +++++++++++
 tb/tb_ls_mem_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ls_mem_ctrl_pkg.sv
// ls_mem_ctrl_pkg: shared state, exception-cause and access-size definitions for the load/store memory stage.
package ls_mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RSP} ls_state_t;
  localparam logic [3:0] LD_MIS = 4'd4;
  localparam logic [3:0] LD_FLT = 4'd5;
  localparam logic [3:0] ST_MIS = 4'd6;
  localparam logic [3:0] ST_FLT = 4'd7;
  localparam logic [2:0] SZ_B = 3'd1;
  localparam logic [2:0] SZ_H = 3'd2;
  localparam logic [2:0] SZ_W = 3'd4;
endpackage

// File: rtl/ls_mem_ctrl_align.sv
// ls_align: combinational byte-lane steering for stores and extract/extend for loads.
module ls_align
  import ls_mem_ctrl_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic        zext,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  be,
  output logic [31:0] wr_data,
  output logic [31:0] ld_data
);
  logic [31:0] sh;
  always_comb begin
    be = size == SZ_B ? 4'b0001 << off : size == SZ_H ? 4'b0011 << off : size == SZ_W ? 4'b1111 : 4'b0000;
    wr_data = size == SZ_B ? {4{st_data[7:0]}} : size == SZ_H ? {2{st_data[15:0]}} : st_data;
    sh = rd_word >> {off, 3'b000};
    ld_data = size == SZ_B ? {{24{~zext & sh[7]}}, sh[7:0]}
            : size == SZ_H ? {{16{~zext & sh[15]}}, sh[15:0]} : sh;
  end
endmodule

// File: rtl/ls_mem_ctrl.sv
// ls_mem_ctrl: memory-stage load/store controller with a single-outstanding req/ack data port.
module ls_mem_ctrl
  import ls_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int XLEN = 32
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            is_ld,
  input  logic            is_st,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] st_data,
  input  logic [2:0]      size,
  input  logic            zero_ext,
  input  logic            mis,
  output logic            dm_req,
  output logic            dm_rw,
  output logic [XLEN-1:0] dm_addr,
  output logic [3:0]      dm_be,
  output logic [XLEN-1:0] dm_wr_data,
  input  logic [XLEN-1:0] dm_rd_data,
  input  logic            dm_ack,
  input  logic            dm_err,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] ld_data,
  output logic            rsp_exc,
  output logic [3:0]      rsp_cause
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  ls_state_t state, state_nx;
  logic [XLEN-1:0] addr_q, data_q;
  logic [2:0] size_q;
  logic zext_q, st_q, flushed;
  logic [CW-1:0] cnt;
  logic accept, timeout, done, drop, fault;
  logic [3:0] be;
  logic [31:0] wr_data, ld_ext;

  ls_align u_align (
    .off(addr_q[1:0]), .size(size_q), .zext(zext_q), .st_data(data_q), .rd_word(dm_rd_data),
    .be(be), .wr_data(wr_data), .ld_data(ld_ext)
  );

  always_comb begin
    accept = state == IDLE && req_valid && (is_ld || is_st) && !flush;
    timeout = state == REQ && !dm_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
    done = state == REQ && (dm_ack || timeout);
    drop = flushed || flush;
    fault = !dm_ack || dm_err;
  end

  always_ff @(posedge clk_in or negedge reset_in)
    if (!reset_in) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state == IDLE ? (accept ? (mis ? RSP : REQ) : IDLE)
             : state == REQ ? (done ? (drop ? IDLE : RSP) : REQ)
             : (rsp_ready || flush) ? IDLE : RSP;
  end

  always_comb begin
    req_ready = state == IDLE;
    dm_req = state == REQ;
    dm_rw = dm_req && st_q;
    dm_addr = dm_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    dm_be = dm_req ? be : 4'b0000;
    dm_wr_data = dm_req ? wr_data : '0;
    rsp_valid = state == RSP;
  end

  // The bus transaction is never aborted; a flush only suppresses its response.
  always_ff @(posedge clk_in or negedge reset_in)
    if (!reset_in) begin
      addr_q <= '0;
      data_q <= '0;
      size_q <= '0;
      zext_q <= 1'b0;
      st_q <= 1'b0;
      cnt <= '0;
      flushed <= 1'b0;
      ld_data <= '0;
      rsp_exc <= 1'b0;
      rsp_cause <= '0;
    end else begin
      if (accept) begin
        addr_q <= ls_addr;
        data_q <= st_data;
        size_q <= size;
        zext_q <= zero_ext;
        st_q <= is_st;
      end
      cnt <= state == REQ ? cnt + 1'b1 : '0;
      flushed <= state == REQ && !done && drop;
      if (accept && mis) begin
        ld_data <= '0;
        rsp_exc <= 1'b1;
        rsp_cause <= is_st ? ST_MIS : LD_MIS;
      end else if (done && !drop) begin
        ld_data <= (st_q || fault) ? '0 : ld_ext;
        rsp_exc <= fault;
        rsp_cause <= fault ? (st_q ? ST_FLT : LD_FLT) : 4'd0;
      end else if (state == RSP && state_nx == IDLE) begin
        ld_data <= '0;
        rsp_exc <= 1'b0;
        rsp_cause <= '0;
      end
    end
endmodule

// File: tb/tb_ls_mem_ctrl.sv
// tb_ls_mem_ctrl: directed vector table plus hand-written multi-cycle sequences for ls_mem_ctrl.
module tb_ls_mem_ctrl;
  logic clk_in = 1'b0, reset_in = 1'b0, flush = 1'b0, req_valid = 1'b0, is_ld = 1'b0, is_st = 1'b0;
  logic [31:0] ls_addr = '0, st_data = '0, dm_rd_data = '0;
  logic [2:0] size = '0;
  logic zero_ext = 1'b0, mis = 1'b0, dm_ack = 1'b0, dm_err = 1'b0, rsp_ready = 1'b0;
  logic req_ready, dm_req, dm_rw, rsp_valid, rsp_exc;
  logic [31:0] dm_addr, dm_wr_data, ld_data;
  logic [3:0] dm_be, rsp_cause;
  int errors = 0, checks = 0;

  ls_mem_ctrl #(.TIMEOUT_CYCLES(16), .XLEN(32)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .is_ld(is_ld), .is_st(is_st), .ls_addr(ls_addr), .st_data(st_data), .size(size),
    .zero_ext(zero_ext), .mis(mis), .dm_req(dm_req), .dm_rw(dm_rw), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wr_data(dm_wr_data), .dm_rd_data(dm_rd_data), .dm_ack(dm_ack),
    .dm_err(dm_err), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .ld_data(ld_data),
    .rsp_exc(rsp_exc), .rsp_cause(rsp_cause)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        st;
    logic [2:0]  sz;
    logic        zx;
    logic [31:0] addr, sd, rd;
    logic [3:0]  be;
    logic [31:0] wd, ld;
  } vec_t;
  vec_t vec[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic start(input logic st, input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz,
                       input logic zx, input logic m);
    req_valid = 1'b1;
    is_st = st;
    is_ld = ~st;
    ls_addr = a;
    st_data = d;
    size = sz;
    zero_ext = zx;
    mis = m;
    step();
    req_valid = 1'b0;
    is_st = 1'b0;
    is_ld = 1'b0;
    mis = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    vec[0] = '{1'b1, 3'd1, 1'b0, 32'h1003, 32'h000000A5, 32'h0,        4'b1000, 32'hA5A5A5A5, 32'h0};
    vec[1] = '{1'b0, 3'd2, 1'b0, 32'h2002, 32'h0,        32'h80FF1234, 4'b1100, 32'h0,        32'hFFFF80FF};
    vec[2] = '{1'b0, 3'd2, 1'b1, 32'h2002, 32'h0,        32'h80FF1234, 4'b1100, 32'h0,        32'h000080FF};
    vec[3] = '{1'b0, 3'd1, 1'b0, 32'h4001, 32'h0,        32'h12348056, 4'b0010, 32'h0,        32'hFFFFFF80};
    vec[4] = '{1'b0, 3'd1, 1'b1, 32'h4000, 32'h0,        32'h123480F6, 4'b0001, 32'h0,        32'h000000F6};
    vec[5] = '{1'b0, 3'd4, 1'b0, 32'h5000, 32'h0,        32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF};
    vec[6] = '{1'b1, 3'd2, 1'b0, 32'h6002, 32'h1234ABCD, 32'h0,        4'b1100, 32'hABCDABCD, 32'h0};
    vec[7] = '{1'b1, 3'd4, 1'b0, 32'h7000, 32'hCAFEF00D, 32'h0,        4'b1111, 32'hCAFEF00D, 32'h0};
    vec[8] = '{1'b0, 3'd1, 1'b0, 32'h4003, 32'h0,        32'h7F000000, 4'b1000, 32'h0,        32'h0000007F};

    #3;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset dm_req", 32'(dm_req), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset ld_data", ld_data, 32'd0);
    chk("reset dm_addr", dm_addr, 32'd0);
    chk("reset dm_be", 32'(dm_be), 32'd0);
    chk("reset rsp_cause", 32'(rsp_cause), 32'd0);
    #9 reset_in = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'd1);
      start(vec[i].st, vec[i].addr, vec[i].sd, vec[i].sz, vec[i].zx, 1'b0);
      chk($sformatf("v%0d dm_req", i), 32'(dm_req), 32'd1);
      chk($sformatf("v%0d dm_rw", i), 32'(dm_rw), 32'(vec[i].st));
      chk($sformatf("v%0d dm_addr", i), dm_addr, vec[i].addr & 32'hFFFF_FFFC);
      chk($sformatf("v%0d dm_be", i), 32'(dm_be), 32'(vec[i].be));
      chk($sformatf("v%0d dm_wr_data", i), dm_wr_data, vec[i].wd);
      dm_ack = 1'b1;
      dm_rd_data = vec[i].rd;
      step();
      dm_ack = 1'b0;
      chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("v%0d rsp_exc", i), 32'(rsp_exc), 32'd0);
      chk($sformatf("v%0d ld_data", i), ld_data, vec[i].ld);
      finish_rsp();
      chk($sformatf("v%0d idle rsp_valid", i), 32'(rsp_valid), 32'd0);
    end

    start(1'b0, 32'h3001, 32'h0, 3'd4, 1'b0, 1'b1);
    chk("lmis dm_req", 32'(dm_req), 32'd0);
    chk("lmis rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lmis rsp_exc", 32'(rsp_exc), 32'd1);
    chk("lmis rsp_cause", 32'(rsp_cause), 32'd4);
    finish_rsp();
    chk("lmis after dm_req", 32'(dm_req), 32'd0);
    start(1'b1, 32'h3002, 32'h0, 3'd4, 1'b0, 1'b1);
    chk("smis rsp_cause", 32'(rsp_cause), 32'd6);
    finish_rsp();

    start(1'b0, 32'h8000, 32'h0, 3'd4, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 40 && dm_req; i++) begin
      n++;
      step();
    end
    chk("timeout req cycles", 32'(n), 32'd16);
    chk("timeout rsp_valid", 32'(rsp_valid), 32'd1);
    chk("timeout rsp_exc", 32'(rsp_exc), 32'd1);
    chk("timeout rsp_cause", 32'(rsp_cause), 32'd5);
    finish_rsp();

    start(1'b0, 32'h8004, 32'h0, 3'd4, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step();
    chk("late ack dm_req", 32'(dm_req), 32'd1);
    dm_ack = 1'b1;
    dm_rd_data = 32'h0BADF00D;
    step();
    dm_ack = 1'b0;
    chk("late ack rsp_exc", 32'(rsp_exc), 32'd0);
    chk("late ack ld_data", ld_data, 32'h0BADF00D);
    finish_rsp();

    start(1'b1, 32'h9000, 32'h11111111, 3'd4, 1'b0, 1'b0);
    dm_ack = 1'b1;
    dm_err = 1'b1;
    step();
    dm_ack = 1'b0;
    dm_err = 1'b0;
    chk("st err rsp_exc", 32'(rsp_exc), 32'd1);
    chk("st err rsp_cause", 32'(rsp_cause), 32'd7);
    finish_rsp();

    start(1'b0, 32'hA000, 32'h0, 3'd4, 1'b0, 1'b0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush req held c3", 32'(dm_req), 32'd1);
    step();
    chk("flush req held c4", 32'(dm_req), 32'd1);
    dm_ack = 1'b1;
    step();
    dm_ack = 1'b0;
    chk("flush dm_req off", 32'(dm_req), 32'd0);
    chk("flush no rsp_valid", 32'(rsp_valid), 32'd0);
    chk("flush req_ready", 32'(req_ready), 32'd1);

    start(1'b0, 32'h2002, 32'h0, 3'd2, 1'b0, 1'b0);
    dm_ack = 1'b1;
    dm_rd_data = 32'h80FF1234;
    step();
    dm_ack = 1'b0;
    dm_rd_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("stall%0d ld_data", i), ld_data, 32'hFFFF80FF);
      step();
    end
    finish_rsp();
    chk("stall released", 32'(rsp_valid), 32'd0);

    start(1'b0, 32'hC000, 32'h0, 3'd4, 1'b0, 1'b0);
    dm_ack = 1'b1;
    step();
    dm_ack = 1'b0;
    chk("rsp flush valid", 32'(rsp_valid), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("rsp flush dropped", 32'(rsp_valid), 32'd0);
    chk("rsp flush idle", 32'(req_ready), 32'd1);

    flush = 1'b1;
    start(1'b0, 32'hC004, 32'h0, 3'd4, 1'b0, 1'b0);
    flush = 1'b0;
    chk("idle flush no req", 32'(dm_req), 32'd0);
    chk("idle flush ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("no type ignored", 32'(dm_req), 32'd0);
    chk("no type no rsp", 32'(rsp_valid), 32'd0);

    start(1'b0, 32'hB000, 32'h0, 3'd4, 1'b0, 1'b0);
    chk("rst pre dm_req", 32'(dm_req), 32'd1);
    #2 reset_in = 1'b0;
    #1;
    chk("rst async dm_req", 32'(dm_req), 32'd0);
    chk("rst async ready", 32'(req_ready), 32'd1);
    @(posedge clk_in);
    #1 reset_in = 1'b1;
    dm_ack = 1'b1;
    dm_rd_data = 32'h55555555;
    step();
    dm_ack = 1'b0;
    chk("rst late ack no rsp", 32'(rsp_valid), 32'd0);
    chk("rst late ack ready", 32'(req_ready), 32'd1);
    start(1'b0, 32'hB004, 32'h0, 3'd4, 1'b0, 1'b0);
    chk("post rst dm_req", 32'(dm_req), 32'd1);
    dm_ack = 1'b1;
    dm_rd_data = 32'h11223344;
    step();
    dm_ack = 1'b0;
    chk("post rst ld_data", ld_data, 32'h11223344);
    chk("post rst rsp_exc", 32'(rsp_exc), 32'd0);
    finish_rsp();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
